// File: rtl/sd_pkg.sv
// Shared srdy/drdy handshake helpers used by the sd_* pipeline stages.
package sd_pkg;

  localparam int unsigned SD_DEF_WIDTH = 8;

  // A word moves across a port only when both sides agree in the same cycle.
  function automatic logic xfer(input logic srdy, input logic drdy);
    return srdy & drdy;
  endfunction

endpackage

// File: rtl/sd_output.sv
// Single-entry registered egress stage: every p_* output comes straight from a flop,
// and the only combinational path is p_drdy -> ic_drdy.
module sd_output
  import sd_pkg::*;
#(
  parameter int unsigned width = SD_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_srdy,
  output logic             ic_drdy,
  input  logic [width-1:0] ic_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic             load;

  always_comb begin
    // Room exists when empty or when the held word leaves this same cycle.
    ic_drdy  = ~p_srdy_q | p_drdy;
    load     = xfer(ic_srdy, ic_drdy);
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    if (load) begin
      p_srdy_d = 1'b1;
      p_data_d = ic_data;
    end else if (xfer(p_srdy_q, p_drdy)) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;

endmodule

// File: tb/tb_sd_output.sv
// Bench for sd_output: directed scenarios plus a randomized run against an occupancy/FIFO model.
module tb_sd_output;

  logic       clk = 1'b0;
  logic       reset;
  logic       ic_srdy;
  logic       ic_drdy;
  logic [7:0] ic_data;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: whether the stage holds a word, the word shown on p_data,
  // and the in-order list of accepted words not yet seen leaving.
  logic       m_full = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];

  sd_output #(.width(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .ic_srdy (ic_srdy),
    .ic_drdy (ic_drdy),
    .ic_data (ic_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the model from the inputs applied before it.
  task automatic tick();
    logic in_x, out_x;
    @(posedge clk);
    if (reset) begin
      m_full = 1'b0;
      m_data = 8'h00;
      exp_q.delete();
    end else begin
      out_x = m_full & p_drdy;
      in_x  = ic_srdy & (!m_full | p_drdy);
      if (out_x) m_full = 1'b0;
      if (in_x) begin
        m_full = 1'b1;
        m_data = ic_data;
        exp_q.push_back(ic_data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ic_srdy = 1'b1; ic_data = 8'h5A; p_drdy = 1'b0;
    repeat (3) tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++; $display("FAIL reset_p_srdy got %b want 0", p_srdy);
    end
    vectors++;
    if (p_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_p_data got %h want 00", p_data);
    end
    reset = 1'b0; ic_srdy = 1'b0;
    #1;
    vectors++;
    if (ic_drdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_ic_drdy got %b want 1", ic_drdy);
    end
  endtask

  task automatic test_single();
    ic_srdy = 1'b1; ic_data = 8'hA5; p_drdy = 1'b1;
    tick();
    ic_srdy = 1'b0; ic_data = 8'h00;
    #1;
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_out got srdy=%b data=%h want srdy=1 data=a5", p_srdy, p_data);
    end
    tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++; $display("FAIL single_drain got srdy=%b want 0", p_srdy);
    end
  endtask

  task automatic test_stream();
    logic [7:0] w;
    p_drdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      w = 8'(i);
      ic_srdy = 1'b1; ic_data = w;
      #1;
      vectors++;
      if (ic_drdy !== 1'b1) begin
        miscompares++; $display("FAIL stream_ic_drdy word %0d got %b want 1", i, ic_drdy);
      end
      if (i > 1) begin
        vectors++;
        if (p_srdy !== 1'b1 || p_data !== w - 8'd1) begin
          miscompares++;
          $display("FAIL stream_out word %0d got srdy=%b data=%h want srdy=1 data=%h",
                   i, p_srdy, p_data, w - 8'd1);
        end
      end
      tick();
    end
    ic_srdy = 1'b0;
    #1;
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 8'h10) begin
      miscompares++;
      $display("FAIL stream_last got srdy=%b data=%h want srdy=1 data=10", p_srdy, p_data);
    end
    tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++; $display("FAIL stream_empty got srdy=%b want 0", p_srdy);
    end
  endtask

  task automatic test_backpressure();
    ic_srdy = 1'b1; ic_data = 8'h3C; p_drdy = 1'b0;
    tick();
    ic_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (ic_drdy !== 1'b0 || p_srdy !== 1'b1 || p_data !== 8'h3C) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got ic_drdy=%b srdy=%b data=%h want 0 1 3c",
                 i, ic_drdy, p_srdy, p_data);
      end
      tick();
    end
    p_drdy = 1'b1;
    #1;
    vectors++;
    if (ic_drdy !== 1'b1) begin
      miscompares++; $display("FAIL bp_release_ic_drdy got %b want 1", ic_drdy);
    end
    tick();
    ic_srdy = 1'b0;
    #1;
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL bp_refill got srdy=%b data=%h want srdy=1 data=ff", p_srdy, p_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] prev_data = 8'h00;
    logic       stalled = 1'b0;
    logic [7:0] want;
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      ic_srdy = 1'($urandom_range(0, 1));
      p_drdy  = 1'($urandom_range(0, 1));
      ic_data = 8'($urandom);
      #1;
      vectors++;
      if (p_srdy !== m_full || ic_drdy !== (!m_full | p_drdy) || p_data !== m_data) begin
        miscompares++;
        $display("FAIL rand_state cycle %0d got srdy=%b ic_drdy=%b data=%h want %b %b %h",
                 c, p_srdy, ic_drdy, p_data, m_full, !m_full | p_drdy, m_data);
      end
      if (stalled) begin
        vectors++;
        if (p_srdy !== 1'b1 || p_data !== prev_data) begin
          miscompares++;
          $display("FAIL rand_stall cycle %0d got srdy=%b data=%h want srdy=1 data=%h",
                   c, p_srdy, p_data, prev_data);
        end
      end
      if (p_srdy === 1'b1 && p_drdy === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rand_order cycle %0d got %h want nothing", c, p_data);
        end else begin
          want = exp_q.pop_front();
          if (p_data !== want) begin
            miscompares++; $display("FAIL rand_order cycle %0d got %h want %h", c, p_data, want);
          end
        end
      end
      stalled   = (p_srdy === 1'b1) && !p_drdy;
      prev_data = p_data;
      tick();
    end
    vectors++;
    if (exp_q.size() != (m_full ? 1 : 0)) begin
      miscompares++;
      $display("FAIL rand_leftover got %0d words want %0d", exp_q.size(), m_full ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    ic_srdy = 1'b1; ic_data = 8'h77; p_drdy = 1'b0;
    tick();
    ic_srdy = 1'b0;
    tick();
    #1;
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 8'h77) begin
      miscompares++;
      $display("FAIL midrst_full got srdy=%b data=%h want srdy=1 data=77", p_srdy, p_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; p_drdy = 1'b1;
    #1;
    vectors++;
    if (p_srdy !== 1'b0 || p_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_cleared got srdy=%b data=%h want srdy=0 data=00", p_srdy, p_data);
    end
    tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_no_xfer got srdy=%b want 0", p_srdy);
    end
  endtask

  initial begin
    reset = 1'b1; ic_srdy = 1'b0; ic_data = 8'h00; p_drdy = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
